// File: rtl/game_flow_ctrl.sv
// Game flow controller: menu/play/pause/clear/win/lose sequencing with lives, stages and timed skills.
// Optional GAME_BONUS_LIFE_EN: entering CLEAR grants one extra life, saturating at MAX_LIVES.
module game_flow_ctrl #(
   parameter int NUM_STAGES     = 3,
   parameter int INIT_LIVES     = 5,
   parameter int MAX_LIVES      = 9,
   parameter int NUM_SKILLS     = 3,
   parameter int INIT_SKILL_PTS = 3,
   parameter int SKILL_DUR      = 100,
   parameter int CLEAR_HOLD     = 40
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_press,
   input  logic                  pause_press,
   input  logic                  ball_lost,
   input  logic                  bricks_empty,
   input  logic [NUM_SKILLS-1:0] skill_req,
   output logic [2:0]            state,
   output logic [3:0]            stage,
   output logic [7:0]            lives,
   output logic [7:0]            skill_pts,
   output logic [NUM_SKILLS-1:0] skill_active,
   output logic                  load_stage,
   output logic [15:0]           led
);

   typedef enum logic [2:0] {
      S_MENU  = 3'd0,
      S_PLAY  = 3'd1,
      S_PAUSE = 3'd2,
      S_CLEAR = 3'd3,
      S_WIN   = 3'd4,
      S_LOSE  = 3'd5
   } state_e;

   localparam int TW = $clog2(SKILL_DUR + 1);
   localparam int HW = $clog2(CLEAR_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(CLEAR_HOLD - 1);

   state_e                  state_q, state_d;
   logic [3:0]              stage_q, stage_d;
   logic [7:0]              lives_q, lives_d;
   logic [7:0]              pts_q, pts_d;
   logic [NUM_SKILLS-1:0]   active_q, active_d;
   logic [TW-1:0]           timer_q [NUM_SKILLS];
   logic [TW-1:0]           timer_d [NUM_SKILLS];
   logic [HW-1:0]           hold_q, hold_d;
   logic                    load_q, load_d;
   logic [15:0]             led_q, led_d;
   logic                    found;

   // End screens show only their own flag; other states show the lives/points thermometers.
   function automatic logic [15:0] led_of(state_e st, logic [7:0] lv, logic [7:0] pts);
      logic [15:0] l;
      l = '0;
      case (st)
         S_WIN:   l[7] = 1'b1;
         S_LOSE:  l[6] = 1'b1;
         default: begin
            for (int i = 0; i < 5; i++) l[i] = (lv > 8'(i));
            for (int i = 0; i < 3; i++) l[15-i] = (pts > 8'(i));
            l[8] = (st == S_PAUSE);
         end
      endcase
      return l;
   endfunction

   always_comb begin
      // NOTE: every _d gets a default first so no path can leave it unassigned and infer a latch.
      state_d  = state_q;
      stage_d  = stage_q;
      lives_d  = lives_q;
      pts_d    = pts_q;
      active_d = active_q;
      timer_d  = timer_q;
      hold_d   = hold_q;
      load_d   = 1'b0;
      found    = 1'b0;
      case (state_q)
         S_MENU: if (start_press) begin
            state_d  = S_PLAY;
            stage_d  = '0;
            lives_d  = 8'(INIT_LIVES);
            pts_d    = 8'(INIT_SKILL_PTS);
            active_d = '0;
            for (int i = 0; i < NUM_SKILLS; i++) timer_d[i] = '0;
            load_d   = 1'b1;
         end
         S_PLAY: begin
            if (bricks_empty) begin
               state_d  = S_CLEAR;
               hold_d   = '0;
               active_d = '0;
               for (int i = 0; i < NUM_SKILLS; i++) timer_d[i] = '0;
`ifdef GAME_BONUS_LIFE_EN
               if (lives_q < 8'(MAX_LIVES)) lives_d = lives_q + 8'd1;
`endif
            end else if (ball_lost && lives_q <= 8'd1) begin
               state_d  = S_LOSE;
               lives_d  = '0;
               active_d = '0;
               for (int i = 0; i < NUM_SKILLS; i++) timer_d[i] = '0;
            end else begin
               for (int i = 0; i < NUM_SKILLS; i++) begin
                  if (active_q[i]) begin
                     if (timer_q[i] == TW'(1)) begin
                        active_d[i] = 1'b0;
                        timer_d[i]  = '0;
                     end else begin
                        timer_d[i] = timer_q[i] - TW'(1);
                     end
                  end
               end
               for (int i = 0; i < NUM_SKILLS; i++) begin
                  if (!found && skill_req[i] && !active_q[i] && pts_q != 8'd0) begin
                     found       = 1'b1;
                     active_d[i] = 1'b1;
                     timer_d[i]  = TW'(SKILL_DUR);
                     pts_d       = pts_q - 8'd1;
                  end
               end
               if (ball_lost)        lives_d = lives_q - 8'd1;
               else if (pause_press) state_d = S_PAUSE;
            end
         end
         S_PAUSE: if (pause_press) state_d = S_PLAY;
         S_CLEAR: begin
            if (hold_q == HOLD_LAST) begin
               if (stage_q < 4'(NUM_STAGES - 1)) begin
                  stage_d = stage_q + 4'd1;
                  load_d  = 1'b1;
                  state_d = S_PLAY;
               end else begin
                  state_d = S_WIN;
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         S_WIN, S_LOSE: if (start_press) state_d = S_MENU;
         default: state_d = S_MENU;
      endcase
      led_d = led_of(state_d, lives_d, pts_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the skill timers are a handful of flops, not RAM, so they are reset with the rest of the state.
         state_q  <= S_MENU;
         stage_q  <= '0;
         lives_q  <= 8'(INIT_LIVES);
         pts_q    <= 8'(INIT_SKILL_PTS);
         active_q <= '0;
         for (int i = 0; i < NUM_SKILLS; i++) timer_q[i] <= '0;
         hold_q   <= '0;
         load_q   <= 1'b0;
         led_q    <= led_of(S_MENU, 8'(INIT_LIVES), 8'(INIT_SKILL_PTS));
      end else begin
         // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
         state_q  <= state_d;
         stage_q  <= stage_d;
         lives_q  <= lives_d;
         pts_q    <= pts_d;
         active_q <= active_d;
         timer_q  <= timer_d;
         hold_q   <= hold_d;
         load_q   <= load_d;
         led_q    <= led_d;
      end
   end

   assign state        = state_q;
   assign stage        = stage_q;
   assign lives        = lives_q;
   assign skill_pts    = pts_q;
   assign skill_active = active_q;
   assign load_stage   = load_q;
   assign led          = led_q;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of playable stages (1..15).
REQ-002 SHALL have parameter INIT_LIVES, default 5, lives loaded at game start (1..MAX_LIVES).
REQ-003 SHALL have parameter MAX_LIVES, default 9, life counter saturation value (<=255).
REQ-004 SHALL have parameter NUM_SKILLS, default 3, independent skill channels (1..8).
REQ-005 SHALL have parameter INIT_SKILL_PTS, default 3, shared skill points at game start.
REQ-006 SHALL have parameter SKILL_DUR, default 100, active cycles per skill activation (>=1).
REQ-007 SHALL have parameter CLEAR_HOLD, default 40, cycles spent in CLEAR before next stage (>=1).
REQ-008 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-009 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-010 SHALL have port start_press  input  1  one-cycle start/confirm pulse.
REQ-011 SHALL have port pause_press  input  1  one-cycle pause toggle pulse.
REQ-012 SHALL have port ball_lost  input  1  one-cycle pulse, ball passed bottom edge.
REQ-013 SHALL have port bricks_empty  input  1  level, current stage has no bricks.
REQ-014 SHALL have port skill_req  input  NUM_SKILLS  one-cycle request pulse per skill.
REQ-015 SHALL have port state  output  3  MENU=0, PLAY=1, PAUSE=2, CLEAR=3, WIN=4, LOSE=5.
REQ-016 SHALL have port stage  output  4  current stage index, 0-based.
REQ-017 SHALL have port lives  output  8  remaining lives.
REQ-018 SHALL have port skill_pts  output  8  remaining shared skill points.
REQ-019 SHALL have port skill_active  output  NUM_SKILLS  per-skill active flag.
REQ-020 SHALL have port load_stage  output  1  one-cycle pulse: load brick map for stage.
REQ-021 SHALL have port led  output  16  status LEDs.

Function
REQ-022 All outputs SHALL be registered; input effects SHALL appear one cycle after the sampling edge.
REQ-023 MENU: start_press -> PLAY, stage=0, lives=INIT_LIVES, skill_pts=INIT_SKILL_PTS, load_stage pulse.
REQ-024 PLAY: priority bricks_empty > ball_lost > pause_press.
REQ-025 PLAY with bricks_empty -> CLEAR, hold counter=0, all skill_active cleared, concurrent ball_lost ignored.
REQ-026 PLAY with ball_lost: lives>1 -> lives-1 stay PLAY; lives==1 -> lives=0, LOSE.
REQ-027 PLAY/PAUSE: pause_press toggles PLAY<->PAUSE; in PAUSE ball_lost, bricks_empty, skill_req ignored and skill timers frozen.
REQ-028 CLEAR: after CLEAR_HOLD cycles, stage<NUM_STAGES-1 -> stage+1, load_stage pulse, PLAY; else -> WIN, stage unchanged.
REQ-029 WIN/LOSE: start_press -> MENU; counters hold their values until next game start.
REQ-030 Skill accept only in PLAY with skill_pts>0 and target skill inactive; only lowest-index eligible request accepted per cycle, others dropped.
REQ-031 Accepted skill: skill_pts-1, skill_active[i]=1 for exactly SKILL_DUR PLAY cycles, then 0; re-request while active dropped without charge.
REQ-032 skill_pts SHALL never underflow; lives SHALL never exceed MAX_LIVES nor underflow.
REQ-033 led[4:0] thermometer of min(lives,5); led[15:13] thermometer of min(skill_pts,3) MSB-first; led[8]=PAUSE; led[7]=WIN; led[6]=LOSE; others 0.
REQ-034 Unused state encodings SHALL return to MENU next cycle.

Reset
REQ-035 rst SHALL, on the clock edge, force state=MENU, stage=0, lives=INIT_LIVES, skill_pts=INIT_SKILL_PTS, skill_active=0, load_stage=0, timers=0, led reflecting those values.
REQ-036 rst mid-game, including CLEAR or active skill, SHALL abandon progress with no load_stage pulse.

Configuration
REQ-037 With GAME_BONUS_LIFE_EN defined, entry to CLEAR SHALL add 1 life, saturating at MAX_LIVES; without it lives SHALL be unchanged on clear.

Verification
REQ-038 Reset, start_press -> next cycle state=1, stage=0, lives=5, skill_pts=3, load_stage=1 for one cycle, led=16'hE01F.
REQ-039 Five ball_lost pulses in PLAY -> lives 4,3,2,1 then lives=0, state=5, led=16'h0040.
REQ-040 bricks_empty and ball_lost same cycle at stage 0 -> CLEAR, lives unchanged (6 with GAME_BONUS_LIFE_EN), PLAY stage 1 with load_stage after 40 cycles.
REQ-041 skill_req=3'b011 in PLAY -> only skill 0 active, skill_pts=2, active exactly 100 PLAY cycles; 20-cycle PAUSE mid-way extends wall time to 120.
REQ-042 skill_pts=0, skill_req=3'b100 -> no activation, skill_pts stays 0; clearing stage 2 of 3 -> WIN, led=16'h0080.
